// File: rtl/psm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : psm_pkg                                                         |
// | Purpose  : Shared types, widths and helpers for power_safety_monitor.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package psm_pkg;

    localparam int PSM_DATA_W = 12;
    localparam int PSM_CNT_W  = 16;
    localparam int PSM_EVT_W  = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } psm_state_t;

    function automatic logic [PSM_EVT_W-1:0] sat_inc(
        input logic [PSM_EVT_W-1:0] cnt,
        input logic [PSM_EVT_W-1:0] limit
    );
        return (cnt >= limit) ? limit : cnt + PSM_EVT_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/psm_event_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : psm_event_counter                                               |
// | Purpose  : Saturating consecutive-event counter; trip marks the event      |
// |            that brings the count to LIMIT.                                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module psm_event_counter
    import psm_pkg::*;
#(
    parameter int LIMIT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    input  logic sync_clr,
    output logic trip
);

    localparam logic [PSM_EVT_W-1:0] c_LIMIT = PSM_EVT_W'(LIMIT);

    logic [PSM_EVT_W-1:0] r_cnt;
    logic [PSM_EVT_W-1:0] w_cnt_inc;

    assign w_cnt_inc = sat_inc(r_cnt, c_LIMIT);
    assign trip      = inc && (w_cnt_inc == c_LIMIT);

    // A trip overrides a coincident clear and reloads the count to the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (trip) begin
            r_cnt <= c_LIMIT;
        end else if (clr || sync_clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= w_cnt_inc;
        end
    end

endmodule
`default_nettype wire

// File: rtl/power_safety_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : power_safety_monitor                                            |
// | Purpose  : Laser-power sample monitor with over/under/missing fault        |
// |            latching and laser_enable interlock. PSM_UNDER_CHECK_EN         |
// |            enables the under-power check.                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module power_safety_monitor
    import psm_pkg::*;
#(
    parameter int DATA_W         = PSM_DATA_W,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int FAULT_LIMIT    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 laser_pulse,
    input  logic                 adc_data_valid,
    input  logic [15:0]          adc_data_value,
    input  logic [DATA_W-1:0]    hi_thresh,
    input  logic [DATA_W-1:0]    lo_thresh,
    input  logic                 clear_peak,
    input  logic                 clear_fault,
    output logic [DATA_W-1:0]    last_power,
    output logic [DATA_W-1:0]    peak_power,
    output logic                 fault_over,
    output logic                 fault_under,
    output logic                 fault_missing,
    output logic                 laser_enable,
    output logic [PSM_CNT_W-1:0] sample_count
);

    localparam int                 c_TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CYCLES - 1);

    psm_state_t          r_state, w_state_nxt;
    logic [c_TMR_W-1:0]  r_timer, w_timer_nxt;
    logic                r_pulse, r_pulse_d;
    logic                w_pulse_rise, w_miss;
    logic [DATA_W-1:0]   w_sample, r_last, r_peak;
    logic [PSM_CNT_W-1:0] r_count;
    logic                w_over, w_trip_over, w_trip_miss;
    logic                r_fault_over, r_fault_missing, w_fault_under, r_laser_enable;

    assign w_sample     = adc_data_value[DATA_W-1:0];
    assign w_pulse_rise = r_pulse & ~r_pulse_d;
    assign w_over       = w_sample > hi_thresh;

    generate
        if (DATA_W < 16) begin : g_unused_hi
            logic w_unused_hi;
            assign w_unused_hi = ^adc_data_value[15:DATA_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_pulse   <= 1'b0;
            r_pulse_d <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_pulse   <= laser_pulse;
            r_pulse_d <= r_pulse;
        end
    end

    // A sample landing on the final window cycle beats the timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_miss      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pulse_rise) begin
                    w_state_nxt = ST_WAIT;
                    w_timer_nxt = '0;
                end
            end
            ST_WAIT: begin
                w_timer_nxt = r_timer + c_TMR_W'(1);
                if (adc_data_valid) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_timer == c_TMR_LAST) begin
                    w_miss      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    psm_event_counter #(.LIMIT(FAULT_LIMIT)) u_over_cnt (
        .clk(clk), .rst(rst),
        .inc(adc_data_valid & w_over), .clr(adc_data_valid & ~w_over),
        .sync_clr(clear_fault), .trip(w_trip_over)
    );

    psm_event_counter #(.LIMIT(FAULT_LIMIT)) u_miss_cnt (
        .clk(clk), .rst(rst),
        .inc(w_miss), .clr(adc_data_valid),
        .sync_clr(clear_fault), .trip(w_trip_miss)
    );

`ifdef PSM_UNDER_CHECK_EN
    logic w_under, w_trip_under, r_fault_under;

    assign w_under = ~w_over & (w_sample < lo_thresh);

    psm_event_counter #(.LIMIT(FAULT_LIMIT)) u_under_cnt (
        .clk(clk), .rst(rst),
        .inc(adc_data_valid & w_under), .clr(adc_data_valid & ~w_under),
        .sync_clr(clear_fault), .trip(w_trip_under)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fault_under <= 1'b0;
        end else if (w_trip_under) begin
            r_fault_under <= 1'b1;
        end else if (clear_fault) begin
            r_fault_under <= 1'b0;
        end
    end

    assign w_fault_under = r_fault_under;
`else
    logic w_unused_lo;
    assign w_unused_lo   = ^lo_thresh;
    assign w_fault_under = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last          <= '0;
            r_peak          <= '0;
            r_count         <= '0;
            r_fault_over    <= 1'b0;
            r_fault_missing <= 1'b0;
            r_laser_enable  <= 1'b1;
        end else begin
            if (adc_data_valid) begin
                r_last  <= w_sample;
                r_count <= r_count + PSM_CNT_W'(1);
                if (clear_peak || (w_sample > r_peak)) begin
                    r_peak <= w_sample;
                end
            end else if (clear_peak) begin
                r_peak <= '0;
            end

            if (w_trip_over) begin
                r_fault_over <= 1'b1;
            end else if (clear_fault) begin
                r_fault_over <= 1'b0;
            end

            if (w_trip_miss) begin
                r_fault_missing <= 1'b1;
            end else if (clear_fault) begin
                r_fault_missing <= 1'b0;
            end

            r_laser_enable <= ~(r_fault_over | w_fault_under | r_fault_missing);
        end
    end

    assign last_power    = r_last;
    assign peak_power    = r_peak;
    assign sample_count  = r_count;
    assign fault_over    = r_fault_over;
    assign fault_under   = w_fault_under;
    assign fault_missing = r_fault_missing;
    assign laser_enable  = r_laser_enable;

endmodule
`default_nettype wire

// File: tb/tb_power_safety_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_power_safety_monitor                                         |
// | Purpose  : Directed self-checking bench for power_safety_monitor with a    |
// |            scoreboard of expected outputs. Honours PSM_UNDER_CHECK_EN.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_power_safety_monitor;

    localparam int LIM = 3;

    logic        clk;
    logic        rst;
    logic        laser_pulse;
    logic        adc_data_valid;
    logic [15:0] adc_data_value;
    logic [11:0] hi_thresh;
    logic [11:0] lo_thresh;
    logic        clear_peak;
    logic        clear_fault;
    logic [11:0] last_power;
    logic [11:0] peak_power;
    logic        fault_over;
    logic        fault_under;
    logic        fault_missing;
    logic        laser_enable;
    logic [15:0] sample_count;

    power_safety_monitor #(
        .DATA_W(12), .TIMEOUT_CYCLES(64), .FAULT_LIMIT(LIM)
    ) dut (
        .clk(clk), .rst(rst), .laser_pulse(laser_pulse),
        .adc_data_valid(adc_data_valid), .adc_data_value(adc_data_value),
        .hi_thresh(hi_thresh), .lo_thresh(lo_thresh),
        .clear_peak(clear_peak), .clear_fault(clear_fault),
        .last_power(last_power), .peak_power(peak_power),
        .fault_over(fault_over), .fault_under(fault_under),
        .fault_missing(fault_missing), .laser_enable(laser_enable),
        .sample_count(sample_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] last;
        logic [11:0] peak;
        logic [15:0] cnt;
        logic        fo;
        logic        fu;
        logic        fm;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks;
    int   n_errors;

    logic [11:0] m_last, m_peak;
    logic [15:0] m_cnt;
    int          m_oc, m_uc, m_mc;
    logic        m_fo, m_fu, m_fm;
    logic        under_en;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last = '0; m_peak = '0; m_cnt = '0;
        m_oc = 0; m_uc = 0; m_mc = 0;
        m_fo = 1'b0; m_fu = 1'b0; m_fm = 1'b0;
    endtask

    task automatic push_exp();
        exp_t e;
        e = '{last: m_last, peak: m_peak, cnt: m_cnt, fo: m_fo, fu: m_fu, fm: m_fm};
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, "_last"},  32'(last_power),    32'(e.last));
            check({tag, "_peak"},  32'(peak_power),    32'(e.peak));
            check({tag, "_count"}, 32'(sample_count),  32'(e.cnt));
            check({tag, "_fover"}, 32'(fault_over),    32'(e.fo));
            check({tag, "_funder"},32'(fault_under),   32'(e.fu));
            check({tag, "_fmiss"}, 32'(fault_missing), 32'(e.fm));
        end
    endtask

    // Behavioural model of one sample, including a coincident clear_fault.
    task automatic model_sample(input logic [11:0] s, input logic cp, input logic cf);
        logic over, under, trip_o, trip_u;
        int   noc, nuc;
        over  = s > hi_thresh;
        under = under_en && !over && (s < lo_thresh);
        m_last = s;
        m_peak = (cp || s > m_peak) ? s : m_peak;
        m_cnt  = m_cnt + 16'd1;
        noc = over  ? ((m_oc + 1 > LIM) ? LIM : m_oc + 1) : 0;
        nuc = under ? ((m_uc + 1 > LIM) ? LIM : m_uc + 1) : 0;
        trip_o = over  && (noc == LIM);
        trip_u = under && (nuc == LIM);
        m_mc = 0;
        if (cf) begin
            m_fo = trip_o; m_fu = trip_u; m_fm = 1'b0;
            m_oc = trip_o ? LIM : 0;
            m_uc = trip_u ? LIM : 0;
        end else begin
            m_fo = m_fo | trip_o; m_fu = m_fu | trip_u;
            m_oc = noc; m_uc = nuc;
        end
    endtask

    task automatic send(input string tag, input logic [15:0] v, input logic cp, input logic cf);
        adc_data_valid = 1'b1; adc_data_value = v; clear_peak = cp; clear_fault = cf;
        model_sample(v[11:0], cp, cf);
        push_exp();
        @(negedge clk);
        adc_data_valid = 1'b0; clear_peak = 1'b0; clear_fault = 1'b0;
        pop_check(tag);
    endtask

    task automatic do_clear_fault(input string tag);
        logic en_before;
        en_before = !(m_fo | m_fu | m_fm);
        clear_fault = 1'b1;
        m_oc = 0; m_uc = 0; m_mc = 0;
        m_fo = 1'b0; m_fu = 1'b0; m_fm = 1'b0;
        push_exp();
        @(negedge clk);
        clear_fault = 1'b0;
        pop_check(tag);
        check({tag, "_en_n1"}, 32'(laser_enable), 32'(en_before));
        @(negedge clk);
        check({tag, "_en_n2"}, 32'(laser_enable), 32'd1);
    endtask

    // Pulse in cycle P with no sample; miss lands at P+65, flag visible at P+66.
    task automatic pulse_miss(input string tag);
        logic fm_before;
        fm_before = m_fm;
        laser_pulse = 1'b1;
        m_mc = (m_mc + 1 > LIM) ? LIM : m_mc + 1;
        if (m_mc == LIM) m_fm = 1'b1;
        push_exp();
        @(negedge clk);
        laser_pulse = 1'b0;
        repeat (64) @(negedge clk);
        check({tag, "_fmiss_p65"}, 32'(fault_missing), 32'(fm_before));
        @(negedge clk);
        pop_check(tag);
    endtask

    task automatic pulse_sample(input string tag, input logic [15:0] v);
        laser_pulse = 1'b1;
        @(negedge clk);
        laser_pulse = 1'b0;
        repeat (64) @(negedge clk);
        send(tag, v, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_checks = 0; n_errors = 0;
`ifdef PSM_UNDER_CHECK_EN
        under_en = 1'b1;
`else
        under_en = 1'b0;
`endif
        rst = 1'b1; laser_pulse = 1'b0; adc_data_valid = 1'b0; adc_data_value = '0;
        hi_thresh = 12'hA00; lo_thresh = 12'h080; clear_peak = 1'b0; clear_fault = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        push_exp();
        pop_check("reset");
        check("reset_en", 32'(laser_enable), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Basic tracking.
        send("s100", 16'h0100, 1'b0, 1'b0);
        send("s800", 16'h0800, 1'b0, 1'b0);
        send("s300", 16'hF300, 1'b0, 1'b0);
        check("t1_last",  32'(last_power),   32'h300);
        check("t1_peak",  32'(peak_power),   32'h800);
        check("t1_count", 32'(sample_count), 32'd3);
        check("t1_en",    32'(laser_enable), 32'd1);

        // Over-power trip after three consecutive samples.
        send("ov1", 16'h0B00, 1'b0, 1'b0);
        send("ov2", 16'h0B00, 1'b0, 1'b0);
        send("ov3", 16'h0B00, 1'b0, 1'b0);
        check("ov3_fover", 32'(fault_over),   32'd1);
        check("ov3_en_n1", 32'(laser_enable), 32'd1);
        @(negedge clk);
        check("ov3_en_n2", 32'(laser_enable), 32'd0);
        do_clear_fault("clr1");

        // Threshold equality is in range; an in-range sample resets the run.
        send("eq",  16'h0A00, 1'b0, 1'b0);
        send("r1",  16'h0B00, 1'b0, 1'b0);
        send("r2",  16'h0500, 1'b0, 1'b0);
        send("r3",  16'h0B00, 1'b0, 1'b0);
        send("r4",  16'h0B00, 1'b0, 1'b0);
        check("run_fover", 32'(fault_over), 32'd0);
        // Trip coinciding with clear_fault keeps the flag set.
        send("trip_clr", 16'h0B00, 1'b0, 1'b1);
        check("trip_clr_fover", 32'(fault_over), 32'd1);
        do_clear_fault("clr2");

        // clear_peak together with a sample loads the sample.
        send("cpeak", 16'h0200, 1'b1, 1'b0);
        check("cpeak_peak", 32'(peak_power), 32'h200);

        // Under-power samples.
        send("un1", 16'h0040, 1'b0, 1'b0);
        send("un2", 16'h0040, 1'b0, 1'b0);
        send("un3", 16'h0040, 1'b0, 1'b0);
        check("un3_funder", 32'(fault_under), 32'(under_en));
        do_clear_fault("clr3");

        // Missing samples after laser pulses.
        pulse_miss("miss1");
        pulse_miss("miss2");
        pulse_miss("miss3");
        check("miss3_fmiss", 32'(fault_missing), 32'd1);
        @(negedge clk);
        check("miss3_en", 32'(laser_enable), 32'd0);
        do_clear_fault("clr4");

        pulse_miss("rmiss1");
        pulse_miss("rmiss2");
        pulse_sample("late", 16'h0400);
        check("late_fmiss", 32'(fault_missing), 32'd0);
        pulse_miss("rmiss3");
        check("rmiss3_fmiss", 32'(fault_missing), 32'd0);

        // Reset during WAIT abandons the pending timeout.
        laser_pulse = 1'b1;
        @(negedge clk);
        laser_pulse = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        push_exp();
        repeat (200) @(negedge clk);
        pop_check("rst_wait");
        check("rst_wait_en", 32'(laser_enable), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
